// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI-lite arbiter.
package axi_arb_pkg;
  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the master not granted last wins.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] last,
  output logic [NUM_MASTERS-1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) gnt = (last == 2'b01) ? 2'b10 : 2'b01;
    else              gnt = req;
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Arbitrates IFU (0) and LSU (1) AXI-lite masters onto one slave, one
// transaction at a time, with round-robin selection and write-before-read.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_araddr_i,
  input  logic [NUM_MASTERS-1:0]                 m_arvalid_i,
  output logic [NUM_MASTERS-1:0]                 m_arready_o,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_rdata_o,
  output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
  input  logic [NUM_MASTERS-1:0]                 m_rready_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_awaddr_i,
  input  logic [NUM_MASTERS-1:0]                 m_awvalid_i,
  output logic [NUM_MASTERS-1:0]                 m_awready_o,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NUM_MASTERS-1:0][STRB_WIDTH-1:0] m_wstrb_i,
  input  logic [NUM_MASTERS-1:0]                 m_wvalid_i,
  output logic [NUM_MASTERS-1:0]                 m_wready_o,
  output logic [NUM_MASTERS-1:0][1:0]            m_bresp_o,
  output logic [NUM_MASTERS-1:0]                 m_bvalid_o,
  input  logic [NUM_MASTERS-1:0]                 m_bready_i,
  output logic [ADDR_WIDTH-1:0]                  s_araddr_o,
  output logic                                   s_arvalid_o,
  input  logic                                   s_arready_i,
  input  logic [DATA_WIDTH-1:0]                  s_rdata_i,
  input  logic                                   s_rvalid_i,
  output logic                                   s_rready_o,
  output logic [ADDR_WIDTH-1:0]                  s_awaddr_o,
  output logic                                   s_awvalid_o,
  input  logic                                   s_awready_i,
  output logic [DATA_WIDTH-1:0]                  s_wdata_o,
  output logic [STRB_WIDTH-1:0]                  s_wstrb_o,
  output logic                                   s_wvalid_o,
  input  logic                                   s_wready_i,
  input  logic [1:0]                             s_bresp_i,
  input  logic                                   s_bvalid_i,
  output logic                                   s_bready_o,
  output logic [NUM_MASTERS-1:0]                 grant_o,
  output logic                                   busy_o
);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, last_q, req, wr_req, sel;
  logic                   ar_done_q, aw_done_q, w_done_q;
  logic                   g;

  assign wr_req  = m_awvalid_i | m_wvalid_i;
  assign req     = m_arvalid_i | wr_req;
  assign g       = grant_q[1];
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ARB_IDLE);

  rr_arb2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (sel)
  );

  // Address-phase done flags stop a master that keeps valid high from
  // issuing a second address inside the same granted transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      last_q    <= 2'b10;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ARB_IDLE) begin
        grant_q <= '0;
      end else if (state_q == ARB_IDLE) begin
        grant_q <= sel;
        last_q  <= sel;
      end
      if (state_q == ARB_IDLE) begin
        ar_done_q <= 1'b0;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (s_arvalid_o && s_arready_i) ar_done_q <= 1'b1;
        if (s_awvalid_o && s_awready_i) aw_done_q <= 1'b1;
        if (s_wvalid_o && s_wready_i)   w_done_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (|sel) state_d = wr_req[sel[1]] ? ARB_WRITE : ARB_READ;
      ARB_READ:  if (s_rvalid_i && s_rready_o) state_d = ARB_IDLE;
      ARB_WRITE: if (s_bvalid_i && s_bready_o) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_arready_o = '0;
    m_rdata_o   = '0;
    m_rvalid_o  = '0;
    m_awready_o = '0;
    m_wready_o  = '0;
    m_bresp_o   = '0;
    m_bvalid_o  = '0;
    s_araddr_o  = '0;
    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    s_awaddr_o  = '0;
    s_awvalid_o = 1'b0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    s_wvalid_o  = 1'b0;
    s_bready_o  = 1'b0;
    case (state_q)
      ARB_READ: begin
        s_araddr_o     = m_araddr_i[g];
        s_arvalid_o    = m_arvalid_i[g] & ~ar_done_q;
        m_arready_o[g] = s_arready_i & ~ar_done_q;
        m_rdata_o[g]   = s_rdata_i;
        m_rvalid_o[g]  = s_rvalid_i;
        s_rready_o     = m_rready_i[g];
      end
      ARB_WRITE: begin
        s_awaddr_o     = m_awaddr_i[g];
        s_awvalid_o    = m_awvalid_i[g] & ~aw_done_q;
        m_awready_o[g] = s_awready_i & ~aw_done_q;
        s_wdata_o      = m_wdata_i[g];
        s_wstrb_o      = m_wstrb_i[g];
        s_wvalid_o     = m_wvalid_i[g] & ~w_done_q;
        m_wready_o[g]  = s_wready_i & ~w_done_q;
        m_bresp_o[g]   = s_bresp_i;
        m_bvalid_o[g]  = s_bvalid_i;
        s_bready_o     = m_bready_i[g];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: hand-computed expectations per step.
module tb_axi_lite_arbiter;
  logic             clk, rst;
  logic [1:0][31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [1:0]       m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]       m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0][3:0]  m_wstrb;
  logic [1:0][1:0]  m_bresp;
  logic [31:0]      s_araddr, s_rdata, s_awaddr, s_wdata;
  logic             s_arvalid, s_arready, s_rvalid, s_rready;
  logic             s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [3:0]       s_wstrb;
  logic [1:0]       s_bresp, grant;
  logic             busy;
  int               pass_cnt = 0;
  int               total = 0;

  axi_lite_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m_araddr_i(m_araddr), .m_arvalid_i(m_arvalid), .m_arready_o(m_arready),
    .m_rdata_o(m_rdata), .m_rvalid_o(m_rvalid), .m_rready_i(m_rready),
    .m_awaddr_i(m_awaddr), .m_awvalid_i(m_awvalid), .m_awready_o(m_awready),
    .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb), .m_wvalid_i(m_wvalid), .m_wready_o(m_wready),
    .m_bresp_o(m_bresp), .m_bvalid_o(m_bvalid), .m_bready_i(m_bready),
    .s_araddr_o(s_araddr), .s_arvalid_o(s_arvalid), .s_arready_i(s_arready),
    .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready),
    .s_awaddr_o(s_awaddr), .s_awvalid_o(s_awvalid), .s_awready_i(s_awready),
    .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb), .s_wvalid_o(s_wvalid), .s_wready_i(s_wready),
    .s_bresp_i(s_bresp), .s_bvalid_i(s_bvalid), .s_bready_o(s_bready),
    .grant_o(grant), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    m_araddr = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = '0;
    s_arready = 1'b0; s_rdata = '0; s_rvalid = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    m_arvalid = 2'b11;
    tick(); tick();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_s_arvalid", 64'(s_arvalid), 64'h0);
    chk("rst_m_arready", 64'(m_arready), 64'h0);
    clr();
    rst = 1'b0;

    // single M0 read
    m_araddr[0] = 32'h8000_0000; m_arvalid = 2'b01;
    #1;
    chk("idle_m_arready", 64'(m_arready), 64'h0);
    chk("idle_s_arvalid", 64'(s_arvalid), 64'h0);
    tick();
    chk("r0_grant", 64'(grant), 64'h1);
    chk("r0_busy", 64'(busy), 64'h1);
    chk("r0_s_araddr", 64'(s_araddr), 64'h8000_0000);
    chk("r0_s_arvalid", 64'(s_arvalid), 64'h1);
    s_arready = 1'b1;
    #1 chk("r0_m_arready", 64'(m_arready), 64'h1);
    tick();
    m_arvalid = '0; s_arready = 1'b0;
    s_rdata = 32'hCAFE_F00D; s_rvalid = 1'b1; m_rready = 2'b01;
    #1;
    chk("r0_rdata0", 64'(m_rdata[0]), 64'hCAFE_F00D);
    chk("r0_rdata1", 64'(m_rdata[1]), 64'h0);
    chk("r0_rvalid", 64'(m_rvalid), 64'h1);
    chk("r0_s_rready", 64'(s_rready), 64'h1);
    chk("r0_busy_hs", 64'(busy), 64'h1);
    tick();
    clr();
    #1;
    chk("r0_busy_end", 64'(busy), 64'h0);
    chk("r0_grant_end", 64'(grant), 64'h0);

    // M0 read vs M1 write right after reset
    rst = 1'b1; #1; rst = 1'b0;
    m_arvalid = 2'b01; m_araddr[0] = 32'h0000_1000;
    m_awvalid = 2'b10; m_wvalid = 2'b10; m_awaddr[1] = 32'h0000_2000;
    m_wdata[1] = 32'h1234_5678; m_wstrb[1] = 4'hF;
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    chk("rw_grant_m0", 64'(grant), 64'h1);
    chk("rw_m1_awready_held", 64'(m_awready), 64'h0);
    chk("rw_m1_wready_held", 64'(m_wready), 64'h0);
    chk("rw_s_awvalid", 64'(s_awvalid), 64'h0);
    s_arready = 1'b1;
    tick();
    m_arvalid = '0; s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b01;
    tick();
    s_rvalid = 1'b0; m_rready = '0;
    #1;
    chk("rw_idle_grant", 64'(grant), 64'h0);
    chk("rw_idle_awready", 64'(m_awready), 64'h0);
    tick();
    chk("rw_grant_m1", 64'(grant), 64'h2);
    chk("rw_m1_awready", 64'(m_awready), 64'h2);
    chk("rw_s_awaddr", 64'(s_awaddr), 64'h2000);
    chk("rw_s_wdata", 64'(s_wdata), 64'h1234_5678);
    tick();
    m_awvalid = '0; m_wvalid = '0; s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 2'b10;
    #1 chk("rw_m_bvalid", 64'(m_bvalid), 64'h2);
    tick();
    s_bvalid = 1'b0; m_bready = '0;
    #1 chk("rw_busy_end", 64'(busy), 64'h0);

    // M1 read+write together: write goes first
    m_arvalid = 2'b10; m_araddr[1] = 32'h0000_3000;
    m_awvalid = 2'b10; m_wvalid = 2'b10; m_awaddr[1] = 32'h0000_4000;
    m_wdata[1] = 32'hDEAD_BEEF; m_wstrb[1] = 4'hF;
    s_arready = 1'b1;
    tick();
    chk("wf_grant", 64'(grant), 64'h2);
    chk("wf_s_arvalid", 64'(s_arvalid), 64'h0);
    chk("wf_m_arready", 64'(m_arready), 64'h0);
    chk("wf_s_wdata", 64'(s_wdata), 64'hDEAD_BEEF);
    chk("wf_s_wstrb", 64'(s_wstrb), 64'hF);
    tick();
    m_awvalid = '0; m_wvalid = '0; s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 2'b10;
    #1;
    chk("wf_bvalid", 64'(m_bvalid), 64'h2);
    chk("wf_bresp", 64'(m_bresp[1]), 64'h0);
    tick();
    s_bvalid = 1'b0; m_bready = '0;
    #1 chk("wf_idle", 64'(grant), 64'h0);
    tick();
    chk("wf_read_grant", 64'(grant), 64'h2);
    chk("wf_read_arvalid", 64'(s_arvalid), 64'h1);
    chk("wf_read_araddr", 64'(s_araddr), 64'h3000);
    tick();
    m_arvalid = '0; s_rvalid = 1'b1; s_rdata = 32'h0000_55AA; m_rready = 2'b10;
    #1 chk("wf_read_rdata", 64'(m_rdata[1]), 64'h55AA);
    tick();
    clr();

    // both masters reading back-to-back alternate
    m_arvalid = 2'b11; m_araddr[0] = 32'hA0; m_araddr[1] = 32'hB0;
    s_arready = 1'b1; s_rvalid = 1'b1; m_rready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_grant%0d", i), 64'(grant), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    clr();
    tick();

    // reset in the middle of a write with bvalid pending
    m_awvalid = 2'b01; m_wvalid = 2'b01; m_awaddr[0] = 32'h5000;
    s_awready = 1'b1; s_wready = 1'b1;
    tick();
    chk("ab_grant", 64'(grant), 64'h1);
    tick();
    m_awvalid = '0; m_wvalid = '0; s_bvalid = 1'b1; m_bready = 2'b01;
    #1;
    chk("ab_bvalid", 64'(m_bvalid), 64'h1);
    rst = 1'b1;
    #1;
    chk("ab_rst_bvalid", 64'(m_bvalid), 64'h0);
    chk("ab_rst_bready", 64'(s_bready), 64'h0);
    chk("ab_rst_grant", 64'(grant), 64'h0);
    chk("ab_rst_busy", 64'(busy), 64'h0);
    clr();
    tick();
    rst = 1'b0;
    m_arvalid = 2'b11;
    tick();
    chk("ab_tie_m0", 64'(grant), 64'h1);
    m_arvalid = '0; s_rvalid = 1'b1; m_rready = 2'b01;
    tick();
    clr();

    // M1 write with W trailing AW by three cycles
    m_awvalid = 2'b10; m_awaddr[1] = 32'h6000; s_awready = 1'b1; s_wready = 1'b1;
    tick();
    chk("lw_grant", 64'(grant), 64'h2);
    chk("lw_s_awvalid", 64'(s_awvalid), 64'h1);
    chk("lw_s_wvalid", 64'(s_wvalid), 64'h0);
    tick();
    m_awvalid = '0;
    tick(); tick();
    chk("lw_grant_held", 64'(grant), 64'h2);
    chk("lw_busy_held", 64'(busy), 64'h1);
    chk("lw_no_reissue", 64'(s_awvalid), 64'h0);
    m_wvalid = 2'b10; m_wdata[1] = 32'hA5A5_A5A5;
    #1;
    chk("lw_s_wvalid_late", 64'(s_wvalid), 64'h1);
    chk("lw_m_wready", 64'(m_wready), 64'h2);
    tick();
    m_wvalid = '0; s_bvalid = 1'b1; s_bresp = 2'b10; m_bready = 2'b11;
    #1;
    chk("lw_bvalid", 64'(m_bvalid), 64'h2);
    chk("lw_bresp1", 64'(m_bresp[1]), 64'h2);
    chk("lw_bresp0", 64'(m_bresp[0]), 64'h0);
    tick();
    s_bvalid = 1'b0;
    #1;
    chk("lw_bvalid_end", 64'(m_bvalid), 64'h0);
    chk("lw_grant_end", 64'(grant), 64'h0);
    chk("lw_busy_end", 64'(busy), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
